cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single ALU-side common data bus (the ROB's _cdb_ready/_cdb_rob_id/_cdb_value inputs) between N execution-unit requesters: ALU, branch/JALR unit, AUIPC/misc unit, and so on.
- Each requester owns a 1-entry holding slot. Slots are served round-robin, and the winner is broadcast from registered outputs one cycle after grant.
- Flushed by the ROB misprediction clear. Sits between the functional units and ReorderBuffer / ReservationStation.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ROB_ID_W, 5, ROB entry id width (ids 1..31; 0 means "none").
- DATA_W, 32, result value width.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; when low the block freezes
- clear_in  input  1  ROB flush (_clear); synchronous, qualified by rdy_in
- req_valid  input  N_REQ  requester i offers a result
- req_rob_id  input  N_REQ*ROB_ID_W  packed ids, requester i at bits [i*ROB_ID_W +: ROB_ID_W]
- req_value  input  N_REQ*DATA_W  packed values, same packing
- req_ready  output  N_REQ  slot i can accept this cycle (combinational)
- cdb_ready  output  1  registered broadcast valid
- cdb_rob_id  output  ROB_ID_W  registered broadcast ROB id
- cdb_value  output  DATA_W  registered broadcast value
- grant_idx  output  3  registered index of the requester currently on the bus (debug/verification)

Behaviour:
- Priority each clock edge: rst_in > (clear_in && rdy_in) > (rdy_in) normal > hold.
- Reset:
  - all slot_valid=0, rr_ptr=0;
  - cdb_ready=0, cdb_rob_id=0, cdb_value=0, grant_idx=0.
- State per slot i: slot_valid[i], slot_id[i], slot_val[i].
- Global state: rr_ptr (index of highest-priority slot for next arbitration).
- Acceptance:
  - req_ready[i] = rdy_in && !clear_in && (!slot_valid[i] || grant[i]).
  - Handshake fires when req_valid[i] && req_ready[i]; the slot loads id/value at that edge.
  - A granted slot may be refilled at the same edge as it drains (back-to-back, one result per cycle per requester, bounded by arbitration).
- Arbitration (combinational, within a cycle):
  - Candidates are slot_valid only. There is no bypass from req_* to the bus.
  - Winner = first valid slot scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ. At most one grant per cycle.
- Broadcast:
  - At an edge with a grant: cdb_ready<=1, cdb_rob_id<=slot_id[w], cdb_value<=slot_val[w], grant_idx<=w, rr_ptr<=(w+1) mod N_REQ.
  - The granted slot clears unless refilled at the same edge.
  - At an edge with no valid slot: cdb_ready<=0, id/value/grant_idx hold, rr_ptr holds.
- Latency:
  - handshake at edge E -> slot valid after E;
  - earliest grant in the following cycle, latched at E+1;
  - cdb_ready high in the cycle after E+1 (2 edges from handshake).
  - cdb_ready is a one-cycle pulse per granted result; consecutive grants give consecutive pulses.
- Fairness: any valid slot is granted within N_REQ cycles of becoming valid.
- clear_in && rdy_in:
  - all slot_valid<=0, cdb_ready<=0, rr_ptr<=0;
  - req_ready all 0 that cycle, so nothing is accepted;
  - cdb_rob_id/cdb_value/grant_idx hold.
- rdy_in low:
  - no state changes, all outputs hold (including cdb_ready=1 if set);
  - req_ready all 0;
  - clear_in is ignored.
- Requester must hold req_valid/id/value stable until the handshake. A req_valid with id 0 is still accepted and broadcast; the block does not check ids.
- Mid-operation reset behaves exactly as the reset state above, at the next edge.

Test Plan:
- Reset: rst_in=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, cdb_ready=0, cdb_rob_id=0, cdb_value=0 throughout.
- Single-request latency: req0 valid (id=5, value=0x1234) at edge E -> cdb_ready=1, cdb_rob_id=5, cdb_value=0x1234, grant_idx=0 in the cycle after E+1 only; cdb_ready=0 the following cycle.
- All 4 requesters fire at once (ids 1,2,3,4) -> broadcasts of ids 1,2,3,4 on 4 consecutive cycles, grant_idx 0,1,2,3.
- Round-robin rotation: after grant_idx=2, slots 0 and 3 both valid -> slot 3 granted before slot 0.
- Backpressure/refill: req1 held valid with new data every cycle while slot1 waits behind slot0 -> req_ready[1]=0 until slot1 is granted, then 1 at the grant edge; the new value is broadcast 2 edges later.
- Clear/freeze:
  - clear_in=1 with slots 1,2 valid -> next cycle cdb_ready=0, no broadcast of those ids ever, rr_ptr=0.
  - rdy_in=0 for 3 cycles with cdb_ready=1 -> outputs unchanged, req_ready=0; resumes with the next slot on rdy_in=1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus between N execution-unit requesters.
// Each requester owns a one-entry holding slot; the winning slot is broadcast from registers.
module cdb_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         clear_in,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*ROB_ID_W-1:0]    req_rob_id,
  input  logic [N_REQ*DATA_W-1:0]      req_value,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         cdb_ready,
  output logic [ROB_ID_W-1:0]          cdb_rob_id,
  output logic [DATA_W-1:0]            cdb_value,
  output logic [2:0]                   grant_idx
);

  logic [N_REQ-1:0]    slot_valid_q, slot_valid_d;
  logic [ROB_ID_W-1:0] slot_id_q  [N_REQ];
  logic [DATA_W-1:0]   slot_val_q [N_REQ];
  logic [2:0]          rr_ptr_q, rr_ptr_d;

  logic                cdb_ready_q;
  logic [ROB_ID_W-1:0] cdb_rob_id_q;
  logic [DATA_W-1:0]   cdb_value_q;
  logic [2:0]          grant_idx_q;

  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    accept;
  logic                any_vld;
  logic [2:0]          win;
  logic [ROB_ID_W-1:0] win_id;
  logic [DATA_W-1:0]   win_val;

  // Scan priority offsets k = 0..N-1 from rr_ptr; the first occupied slot wins.
  always_comb begin
    grant   = '0;
    any_vld = 1'b0;
    win     = '0;
    win_id  = '0;
    win_val = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any_vld && slot_valid_q[i] && (((int'(rr_ptr_q) + k) % N_REQ) == i)) begin
          any_vld  = 1'b1;
          grant[i] = 1'b1;
          win      = 3'(i);
          win_id   = slot_id_q[i];
          win_val  = slot_val_q[i];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = !rst_in && rdy_in && !clear_in && (!slot_valid_q[i] || grant[i]);
    end
    accept       = req_valid & req_ready;
    slot_valid_d = (slot_valid_q & ~grant) | accept;
    rr_ptr_d     = rr_ptr_q;
    if (any_vld) begin
      rr_ptr_d = (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_ready_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      grant_idx_q  <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        slot_valid_q <= '0;
        rr_ptr_q     <= '0;
        cdb_ready_q  <= 1'b0;
      end else begin
        slot_valid_q <= slot_valid_d;
        rr_ptr_q     <= rr_ptr_d;
        cdb_ready_q  <= any_vld;
        if (any_vld) begin
          cdb_rob_id_q <= win_id;
          cdb_value_q  <= win_val;
          grant_idx_q  <= win;
        end
      end
    end
  end

  // Slot payloads need no reset: they are only observed while the matching valid bit is set.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_id_q[i]  <= req_rob_id[i*ROB_ID_W +: ROB_ID_W];
        slot_val_q[i] <= req_value[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cdb_ready  = cdb_ready_q;
  assign cdb_rob_id = cdb_rob_id_q;
  assign cdb_value  = cdb_value_q;
  assign grant_idx  = grant_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic, all checked
// against a slot/distance reference model kept in the bench.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int IW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, rdy, clr;
  logic [N-1:0]    rv;
  logic [N*IW-1:0] rid;
  logic [N*DW-1:0] rval;
  logic [N-1:0]    rr_o;
  logic            cr;
  logic [IW-1:0]   cid;
  logic [DW-1:0]   cval;
  logic [2:0]      gidx;

  cdb_arbiter #(.N_REQ(N), .ROB_ID_W(IW), .DATA_W(DW)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
    .req_valid(rv), .req_rob_id(rid), .req_value(rval),
    .req_ready(rr_o), .cdb_ready(cr), .cdb_rob_id(cid), .cdb_value(cval),
    .grant_idx(gidx)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit            m_v   [N];
  logic [IW-1:0] m_id  [N];
  logic [DW-1:0] m_val [N];
  int            m_age [N];
  int            m_rr;
  bit            m_cr;
  logic [IW-1:0] m_cid;
  logic [DW-1:0] m_cval;
  int            m_gi;
  bit            m_init = 1'b0;
  logic [N-1:0]  acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Winner = occupied slot at the smallest forward distance from the pointer.
  function automatic int m_winner();
    int best, bd, d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) begin
        d = (i - m_rr + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic bit m_rdy(input int i);
    return !rst && rdy && !clr && (!m_v[i] || m_winner() == i);
  endfunction

  task automatic cyc();
    int w;
    @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("req_ready[%0d]", i), 64'(rr_o[i]), 64'(m_rdy(i)));
    if (m_init) begin
      chk("cdb_ready", 64'(cr), 64'(m_cr));
      chk("cdb_rob_id", 64'(cid), 64'(m_cid));
      chk("cdb_value", 64'(cval), 64'(m_cval));
      chk("grant_idx", 64'(gidx), 64'(m_gi));
    end
    @(posedge clk);
    acc = '0;
    for (int i = 0; i < N; i++) acc[i] = rv[i] && m_rdy(i);
    if (rst) begin
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_rr = 0; m_cr = 1'b0; m_cid = '0; m_cval = '0; m_gi = 0;
      m_init = 1'b1;
    end else if (rdy) begin
      if (clr) begin
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        m_rr = 0; m_cr = 1'b0;
      end else begin
        w = m_winner();
        if (w >= 0) begin
          chk("fairness_age", 64'(m_age[w] < N), 64'd1);
          m_cr = 1'b1; m_cid = m_id[w]; m_cval = m_val[w]; m_gi = w;
          m_rr = (w + 1) % N;
          m_v[w] = 1'b0;
        end else begin
          m_cr = 1'b0;
        end
        for (int i = 0; i < N; i++) if (m_v[i]) m_age[i]++;
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            m_v[i]   = 1'b1;
            m_id[i]  = rid[i*IW +: IW];
            m_val[i] = rval[i*DW +: DW];
            m_age[i] = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic [IW-1:0] id, input logic [DW-1:0] v);
    rv[i] = 1'b1;
    rid[i*IW +: IW] = id;
    rval[i*DW +: DW] = v;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    rv = '0; rid = '0; rval = '0;
    for (int i = 0; i < N; i++) set_req(i, IW'(i + 20), DW'(32'hA0 + i));

    // Reset with every requester asserting
    repeat (2) cyc();
    chk("rst_cdb_ready", 64'(cr), 64'd0);
    chk("rst_cdb_rob_id", 64'(cid), 64'd0);
    chk("rst_cdb_value", 64'(cval), 64'd0);

    // Single request latency
    rst = 1'b0; rv = '0;
    set_req(0, 5'd5, 32'h1234);
    cyc();
    rv = '0;
    chk("lat_not_yet", 64'(cr), 64'd0);
    cyc();
    chk("lat_ready", 64'(cr), 64'd1);
    chk("lat_id", 64'(cid), 64'd5);
    chk("lat_val", 64'(cval), 64'h1234);
    chk("lat_gidx", 64'(gidx), 64'd0);
    cyc();
    chk("lat_pulse_end", 64'(cr), 64'd0);

    // Clear then all four requesters at once
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, IW'(i + 1), DW'(100 + i));
    cyc();
    rv = '0;
    for (int k = 0; k < N; k++) begin
      cyc();
      chk("all4_ready", 64'(cr), 64'd1);
      chk("all4_id", 64'(cid), 64'(k + 1));
      chk("all4_gidx", 64'(gidx), 64'(k));
    end

    // Rotation: after slot 2 wins, slot 3 goes ahead of slot 0
    set_req(2, 5'd7, 32'h77);
    cyc();
    rv = '0;
    set_req(0, 5'd8, 32'h88);
    set_req(3, 5'd9, 32'h99);
    cyc();
    rv = '0;
    chk("rot_gidx2", 64'(gidx), 64'd2);
    cyc();
    chk("rot_gidx3", 64'(gidx), 64'd3);
    chk("rot_id9", 64'(cid), 64'd9);
    cyc();
    chk("rot_gidx0", 64'(gidx), 64'd0);
    chk("rot_id8", 64'(cid), 64'd8);

    // Clear drops pending slots 1 and 2
    set_req(1, 5'd10, 32'h10);
    set_req(2, 5'd11, 32'h11);
    cyc();
    rv = '0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_ready", 64'(cr), 64'd0);
    repeat (3) begin
      cyc();
      chk("clr_no_bcast", 64'(cr), 64'd0);
      chk("clr_id_hold", 64'(cid), 64'd8);
    end

    // Freeze while a broadcast is on the bus
    set_req(0, 5'd12, 32'h12);
    set_req(1, 5'd13, 32'h13);
    cyc();
    rv = '0;
    cyc();
    chk("frz_start_id", 64'(cid), 64'd12);
    rdy = 1'b0; clr = 1'b1;
    set_req(2, 5'd14, 32'h14);
    set_req(3, 5'd15, 32'h15);
    repeat (3) begin
      cyc();
      chk("frz_ready", 64'(cr), 64'd1);
      chk("frz_id", 64'(cid), 64'd12);
      chk("frz_rr", 64'(rr_o), 64'd0);
    end
    rdy = 1'b1; clr = 1'b0; rv = '0;
    cyc();
    chk("frz_resume_gidx", 64'(gidx), 64'd1);
    chk("frz_resume_id", 64'(cid), 64'd13);

    // Randomized traffic; requesters hold their offer until the handshake
    acc = '0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++) begin
        if (!rv[i] || acc[i]) begin
          if ($urandom_range(0, 9) < 6) set_req(i, IW'($urandom), DW'($urandom));
          else rv[i] = 1'b0;
        end
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
